// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared decode constants and types for the SimpleRISC hazard controller.
// Instruction layout: opcode[31:27] imm[26] rd[25:22] rs1[21:18] rs2[17:14].
package pipeline_hazard_controller_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_LSL  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_NOP  = 5'd13;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BGT  = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;

  localparam logic [3:0] RA_REG = 4'd15;

  localparam int OPC_LO  = 27;
  localparam int IMM_BIT = 26;
  localparam int RD_LO   = 22;
  localparam int RS1_LO  = 18;
  localparam int RS2_LO  = 14;

  typedef enum logic {ST_RUN, ST_BUSY} state_t;

  typedef struct packed {
    logic       src1_v;
    logic [3:0] src1;
    logic       src2_v;
    logic [3:0] src2;
    logic       dst_v;
    logic [3:0] dst;
    logic       is_muldiv;
  } dec_t;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Stage instruction/valid inputs and latch control outputs of the hazard controller.
// master = pipeline side, slave = controller side.
interface pipeline_hazard_controller_if #(parameter int CNT_W = 16);
  logic [31:0]      of_IR, ex_IR, ma_IR, rw_IR;
  logic             of_valid, ex_valid, ma_valid, rw_valid;
  logic             is_Branch_Taken;
  logic             pc_hold, if_of_hold, if_of_flush, of_ex_hold;
  logic             of_ex_bubble, ex_ma_bubble, muldiv_busy;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  modport master (
    output of_IR, ex_IR, ma_IR, rw_IR, of_valid, ex_valid, ma_valid, rw_valid, is_Branch_Taken,
    input  pc_hold, if_of_hold, if_of_flush, of_ex_hold, of_ex_bubble, ex_ma_bubble,
           muldiv_busy, stall_cycles, flush_count
  );

  modport slave (
    input  of_IR, ex_IR, ma_IR, rw_IR, of_valid, ex_valid, ma_valid, rw_valid, is_Branch_Taken,
    output pc_hold, if_of_hold, if_of_flush, of_ex_hold, of_ex_bubble, ex_ma_bubble,
           muldiv_busy, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_controller_hazard_reg_decode.sv
// Register-usage decoder: which registers an instruction reads and writes.
// Pure combinational; validity of the stage is applied by the caller.
module hazard_reg_decode
  import pipeline_hazard_controller_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);
  logic [4:0] op;
  logic       imm;
  logic [3:0] rd, rs1, rs2;
  logic       is_alu;
  logic       unused_ir;

  assign op        = ir[OPC_LO +: 5];
  assign imm       = ir[IMM_BIT];
  assign rd        = ir[RD_LO +: 4];
  assign rs1       = ir[RS1_LO +: 4];
  assign rs2       = ir[RS2_LO +: 4];
  assign is_alu    = (op <= OP_ASR);
  assign unused_ir = ^ir[RS2_LO-1:0];

  always_comb begin
    dec           = '0;
    dec.is_muldiv = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);

    // not/mov take only the second operand (register or immediate)
    if ((is_alu && op != OP_NOT && op != OP_MOV) || op == OP_LD || op == OP_ST) begin
      dec.src1_v = 1'b1;
      dec.src1   = rs1;
    end
    if (is_alu && !imm) begin
      dec.src2_v = 1'b1;
      dec.src2   = rs2;
    end
    if (op == OP_ST) begin
      dec.src2_v = 1'b1;
      dec.src2   = rd;
    end
    if (op == OP_RET) begin
      dec.src1_v = 1'b1;
      dec.src1   = RA_REG;
    end

    if ((is_alu && op != OP_CMP) || op == OP_LD) begin
      dec.dst_v = 1'b1;
      dec.dst   = rd;
    end
    if (op == OP_CALL) begin
      dec.dst_v = 1'b1;
      dec.dst   = RA_REG;
    end
  end
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline interlock: RAW stall, multi-cycle mul/div/mod hold, taken-branch squash,
// plus saturating stall/flush counters. Control outputs are combinational from stage inputs.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int RW_BYPASS  = 1,
  parameter int CNT_W      = 16
) (
  input logic                         clk,
  input logic                         reset,
  pipeline_hazard_controller_if.slave hz
);
  localparam int            BW     = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [BW-1:0] LAST   = BW'(MULDIV_LAT - 1);
  localparam logic          RW_CHK = (RW_BYPASS == 0);

  dec_t of_dec, ex_dec, ma_dec, rw_dec;

  hazard_reg_decode u_dec_of (.ir(hz.of_IR), .dec(of_dec));
  hazard_reg_decode u_dec_ex (.ir(hz.ex_IR), .dec(ex_dec));
  hazard_reg_decode u_dec_ma (.ir(hz.ma_IR), .dec(ma_dec));
  hazard_reg_decode u_dec_rw (.ir(hz.rw_IR), .dec(rw_dec));

  logic             unused_dec;
  assign unused_dec = ^{of_dec, ex_dec, ma_dec, rw_dec};

  logic [BW-1:0]    busy_cnt_q, busy_cnt_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic raw, muldiv_ex, ex_hold, branch;
  logic pc_hold, if_of_hold, if_of_flush, of_ex_hold, of_ex_bubble, ex_ma_bubble;

  function automatic logic dep(input logic src_v, input logic [3:0] src,
                               input dec_t d, input logic d_vld);
    return src_v & d_vld & d.dst_v & (d.dst == src);
  endfunction

  always_comb begin
    raw = hz.of_valid & (
            dep(of_dec.src1_v, of_dec.src1, ex_dec, hz.ex_valid) |
            dep(of_dec.src1_v, of_dec.src1, ma_dec, hz.ma_valid) |
            (RW_CHK & dep(of_dec.src1_v, of_dec.src1, rw_dec, hz.rw_valid)) |
            dep(of_dec.src2_v, of_dec.src2, ex_dec, hz.ex_valid) |
            dep(of_dec.src2_v, of_dec.src2, ma_dec, hz.ma_valid) |
            (RW_CHK & dep(of_dec.src2_v, of_dec.src2, rw_dec, hz.rw_valid)));
    muldiv_ex = hz.ex_valid & ex_dec.is_muldiv;
    ex_hold   = muldiv_ex & (busy_cnt_q != LAST);
    branch    = hz.is_Branch_Taken;

    pc_hold      = 1'b0;
    if_of_hold   = 1'b0;
    if_of_flush  = 1'b0;
    of_ex_hold   = 1'b0;
    of_ex_bubble = 1'b0;
    ex_ma_bubble = 1'b0;
    if (!reset) begin
      if (branch) begin
        if_of_flush  = 1'b1;
        of_ex_bubble = 1'b1;
      end else if (ex_hold) begin
        pc_hold      = 1'b1;
        if_of_hold   = 1'b1;
        of_ex_hold   = 1'b1;
        ex_ma_bubble = 1'b1;
      end else if (raw) begin
        pc_hold      = 1'b1;
        if_of_hold   = 1'b1;
        of_ex_bubble = 1'b1;
      end
    end

    // A taken branch squashes the op, so the occupancy count restarts.
    busy_cnt_d     = (ex_hold && !branch) ? busy_cnt_q + BW'(1) : '0;
    state_d        = (busy_cnt_d != '0) ? ST_BUSY : ST_RUN;
    stall_cycles_d = stall_cycles_q + CNT_W'(pc_hold && (stall_cycles_q != '1));
    flush_count_d  = flush_count_q + CNT_W'(branch && !reset && (flush_count_q != '1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt_q     <= '0;
      state_q        <= ST_RUN;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      busy_cnt_q     <= busy_cnt_d;
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign hz.pc_hold      = pc_hold;
  assign hz.if_of_hold   = if_of_hold;
  assign hz.if_of_flush  = if_of_flush;
  assign hz.of_ex_hold   = of_ex_hold;
  assign hz.of_ex_bubble = of_ex_bubble;
  assign hz.ex_ma_bubble = ex_ma_bubble;
  assign hz.muldiv_busy  = (state_q == ST_BUSY) & ~reset;
  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_count  = flush_count_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with hand-computed control vectors.
// ctl = {pc_hold, if_of_hold, if_of_flush, of_ex_hold, of_ex_bubble, ex_ma_bubble, muldiv_busy}
module tb_pipeline_hazard_controller;
  import pipeline_hazard_controller_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total  = 0;

  pipeline_hazard_controller_if #(.CNT_W(16)) hz ();

  pipeline_hazard_controller #(.MULDIV_LAT(4), .RW_BYPASS(1), .CNT_W(16)) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz)
  );

  always #5 clk = ~clk;

  logic [6:0] ctl;
  assign ctl = {hz.pc_hold, hz.if_of_hold, hz.if_of_flush, hz.of_ex_hold,
                hz.of_ex_bubble, hz.ex_ma_bubble, hz.muldiv_busy};

  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_RAW    = 7'b1100100;
  localparam logic [6:0] C_HOLD   = 7'b1101010;
  localparam logic [6:0] C_HOLD_B = 7'b1101011;
  localparam logic [6:0] C_BUSY   = 7'b0000001;
  localparam logic [6:0] C_FLUSH  = 7'b0010100;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic imm,
                                     input logic [3:0] rd, input logic [3:0] rs1,
                                     input logic [3:0] rs2);
    return {op, imm, rd, rs1, rs2, 14'd0};
  endfunction

  task automatic drive(input logic [31:0] o, input logic ov, input logic [31:0] e, input logic ev,
                       input logic [31:0] m, input logic mv, input logic [31:0] r, input logic rv,
                       input logic br);
    hz.of_IR = o; hz.of_valid = ov;
    hz.ex_IR = e; hz.ex_valid = ev;
    hz.ma_IR = m; hz.ma_valid = mv;
    hz.rw_IR = r; hz.rw_valid = rv;
    hz.is_Branch_Taken = br;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(mk(OP_SUB, 0, 4, 1, 5), 1, mk(OP_ADD, 0, 1, 2, 3), 1, 0, 0, 0, 0, 0);
    step();
    total++;
    if (ctl !== C_NONE) $display("FAIL reset_ctl got=%b exp=%b", ctl, C_NONE); else passed++;
    total++;
    if (hz.stall_cycles !== 16'd0 || hz.flush_count !== 16'd0)
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", hz.stall_cycles, hz.flush_count);
    else passed++;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_raw_alu();
    logic [31:0] add_i, sub_i;
    add_i = mk(OP_ADD, 0, 1, 2, 3);
    sub_i = mk(OP_SUB, 0, 4, 1, 5);
    do_reset();
    drive(sub_i, 1, add_i, 1, 0, 0, 0, 0, 0);
    total++;
    if (ctl !== C_RAW) $display("FAIL raw_ex got=%b exp=%b", ctl, C_RAW); else passed++;
    step();
    drive(sub_i, 1, mk(OP_NOP, 0, 0, 0, 0), 0, add_i, 1, 0, 0, 0);
    total++;
    if (ctl !== C_RAW) $display("FAIL raw_ma got=%b exp=%b", ctl, C_RAW); else passed++;
    step();
    drive(sub_i, 1, 0, 0, 0, 0, add_i, 1, 0);
    total++;
    if (ctl !== C_NONE) $display("FAIL raw_release got=%b exp=%b", ctl, C_NONE); else passed++;
    total++;
    if (hz.stall_cycles !== 16'd2) $display("FAIL raw_stall_cnt got=%0d exp=2", hz.stall_cycles);
    else passed++;
  endtask

  task automatic test_raw_variants();
    do_reset();
    // immediate form: rs2 field is not a source
    drive(mk(OP_ADD, 1, 4, 1, 5), 1, mk(OP_MOV, 0, 5, 0, 2), 1, 0, 0, 0, 0, 0);
    total++;
    if (ctl !== C_NONE) $display("FAIL imm_no_rs2 got=%b exp=%b", ctl, C_NONE); else passed++;
    drive(mk(OP_RET, 0, 0, 0, 0), 1, mk(OP_CALL, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0);
    total++;
    if (ctl !== C_RAW) $display("FAIL ret_after_call got=%b exp=%b", ctl, C_RAW); else passed++;
    drive(mk(OP_ADD, 0, 4, 6, 6), 1, mk(OP_CMP, 0, 6, 6, 6), 1, 0, 0, 0, 0, 0);
    total++;
    if (ctl !== C_NONE) $display("FAIL cmp_no_dest got=%b exp=%b", ctl, C_NONE); else passed++;
    drive(mk(OP_ADD, 0, 4, 6, 6), 0, mk(OP_MOV, 1, 6, 0, 0), 1, 0, 0, 0, 0, 0);
    total++;
    if (ctl !== C_NONE) $display("FAIL of_invalid got=%b exp=%b", ctl, C_NONE); else passed++;
  endtask

  task automatic test_muldiv();
    logic [31:0] mul_i, oth_i;
    logic [6:0]  exp_seq [4];
    mul_i = mk(OP_MUL, 0, 3, 1, 2);
    oth_i = mk(OP_ADD, 0, 9, 8, 8);
    exp_seq = '{C_HOLD, C_HOLD_B, C_HOLD_B, C_BUSY};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(oth_i, 1, mul_i, 1, 0, 0, 0, 0, 0);
      total++;
      if (ctl !== exp_seq[c]) $display("FAIL muldiv_c%0d got=%b exp=%b", c, ctl, exp_seq[c]);
      else passed++;
      step();
    end
    drive(0, 0, oth_i, 1, mul_i, 1, 0, 0, 0);
    total++;
    if (ctl !== C_NONE) $display("FAIL muldiv_c4 got=%b exp=%b", ctl, C_NONE); else passed++;
  endtask

  task automatic test_branch();
    do_reset();
    drive(mk(OP_ADD, 0, 5, 1, 2), 1, mk(OP_BEQ, 0, 0, 0, 0), 1, mk(OP_ADD, 0, 1, 2, 3), 1, 0, 0, 1);
    total++;
    if (ctl !== C_FLUSH) $display("FAIL branch_ctl got=%b exp=%b", ctl, C_FLUSH); else passed++;
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if (hz.flush_count !== 16'd1 || hz.stall_cycles !== 16'd0)
      $display("FAIL branch_cnt got=%0d/%0d exp=1/0", hz.flush_count, hz.stall_cycles);
    else passed++;
    // branch and muldiv hold together: branch wins and occupancy restarts
    drive(0, 0, mk(OP_MUL, 0, 3, 1, 2), 1, 0, 0, 0, 0, 1);
    step();
    drive(0, 0, mk(OP_MUL, 0, 3, 1, 2), 1, 0, 0, 0, 0, 0);
    total++;
    if (ctl !== C_HOLD) $display("FAIL branch_vs_mul got=%b exp=%b", ctl, C_HOLD); else passed++;
  endtask

  task automatic test_store_load();
    logic [31:0] st_i, ld_i;
    st_i = mk(OP_ST, 1, 7, 2, 0);
    ld_i = mk(OP_LD, 1, 7, 3, 0);
    do_reset();
    drive(st_i, 1, 0, 0, ld_i, 1, 0, 0, 0);
    total++;
    if (ctl !== C_RAW) $display("FAIL st_rd_ma got=%b exp=%b", ctl, C_RAW); else passed++;
    drive(st_i, 1, 0, 0, 0, 0, ld_i, 1, 0);
    total++;
    if (ctl !== C_NONE) $display("FAIL st_rd_rw_bypass got=%b exp=%b", ctl, C_NONE); else passed++;
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] div_i, oth_i;
    logic [6:0]  exp_seq [4];
    div_i = mk(OP_DIV, 0, 6, 1, 2);
    oth_i = mk(OP_ADD, 0, 9, 8, 8);
    exp_seq = '{C_HOLD, C_HOLD_B, C_HOLD_B, C_BUSY};
    do_reset();
    drive(oth_i, 1, div_i, 1, 0, 0, 0, 0, 0);
    step();
    step();
    total++;
    if (ctl !== C_HOLD_B) $display("FAIL div_cnt2 got=%b exp=%b", ctl, C_HOLD_B); else passed++;
    reset = 1'b1;
    #1;
    total++;
    if (ctl !== C_NONE) $display("FAIL div_reset_ctl got=%b exp=%b", ctl, C_NONE); else passed++;
    step();
    reset = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (ctl !== exp_seq[c]) $display("FAIL div_restart_c%0d got=%b exp=%b", c, ctl, exp_seq[c]);
      else passed++;
      step();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(mk(OP_SUB, 0, 4, 1, 5), 1, mk(OP_ADD, 0, 1, 2, 3), 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    total++;
    if (hz.stall_cycles !== 16'hFFFE) $display("FAIL sat_pre got=%h exp=fffe", hz.stall_cycles);
    else passed++;
    for (int i = 0; i < 5; i++) @(posedge clk);
    #1;
    total++;
    if (hz.stall_cycles !== 16'hFFFF) $display("FAIL sat_hold got=%h exp=ffff", hz.stall_cycles);
    else passed++;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_raw_alu();
    test_raw_variants();
    test_muldiv();
    test_branch();
    test_store_load();
    test_reset_mid_busy();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
